// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-ported memory between the fetch (IF) and data (D) ports.
// D has priority; a starvation counter forces an IF grant after STARVE_MAX consecutive D wins.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              d_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t     state_r;
   logic [3:0] wait_cnt_r;
   logic [3:0] starve_cnt_r;
   logic       owner_d_r;
   logic       we_r;
   logic       starved_s;
   logic       grant_d_s;
   logic       grant_if_s;

   // Grant decision, only meaningful while idle
   always_comb begin
      starved_s  = (starve_cnt_r == STARVE_LIM);
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
      if (state_r == IDLE) begin
         if (d_req && !(if_req && starved_s)) begin
            grant_d_s = 1'b1;
         end else if (if_req) begin
            grant_if_s = 1'b1;
         end else begin
            grant_d_s  = 1'b0;
            grant_if_s = 1'b0;
         end
      end else begin
         grant_d_s  = 1'b0;
         grant_if_s = 1'b0;
      end
   end

   assign if_stall = if_req & ~if_valid;
   assign d_stall  = d_req & ~d_valid;

   // Transaction sequencer with registered memory strobes and completion pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         wait_cnt_r   <= 4'd0;
         starve_cnt_r <= 4'd0;
         owner_d_r    <= 1'b0;
         we_r         <= 1'b0;
         if_rdata     <= '0;
         d_rdata      <= '0;
         if_valid     <= 1'b0;
         d_valid      <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         busy         <= 1'b0;
      end else begin
         if_valid  <= 1'b0;
         d_valid   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         case (state_r)
            IDLE: begin
               if (grant_d_s) begin
                  state_r   <= ACCESS;
                  busy      <= 1'b1;
                  owner_d_r <= 1'b1;
                  we_r      <= d_we;
                  mem_en    <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  // IF lost a contested round: count it, saturating
                  if (if_req) begin
                     starve_cnt_r <= starved_s ? starve_cnt_r : starve_cnt_r + 4'd1;
                  end else begin
                     starve_cnt_r <= 4'd0;
                  end
               end else if (grant_if_s) begin
                  state_r      <= ACCESS;
                  busy         <= 1'b1;
                  owner_d_r    <= 1'b0;
                  we_r         <= 1'b0;
                  mem_en       <= 1'b1;
                  mem_addr     <= if_addr;
                  starve_cnt_r <= 4'd0;
               end else begin
                  starve_cnt_r <= 4'd0;
               end
            end
            ACCESS: begin
               state_r    <= WAIT;
               wait_cnt_r <= LAT_INIT;
            end
            WAIT: begin
               if (wait_cnt_r <= 4'd1) begin
                  state_r <= RESP;
                  if (owner_d_r) begin
                     d_valid <= 1'b1;
                     if (!we_r) begin
                        d_rdata <= mem_rdata;
                     end
                  end else begin
                     if_valid <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else begin
                  wait_cnt_r <= wait_cnt_r - 4'd1;
               end
            end
            RESP: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: per-cycle vector table for single accesses, contention and writes (MEM_LAT=2),
// plus hand sequences for reset-in-WAIT and fetch starvation (MEM_LAT=1, STARVE_MAX=2).
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   int          n_checks = 0;
   int          n_fail   = 0;

   // instance A: MEM_LAT=2, STARVE_MAX=4
   logic        if_req, if_valid, if_stall, d_req, d_we, d_valid, d_stall, mem_en, mem_we, busy;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

   // instance B: MEM_LAT=1, STARVE_MAX=2
   logic        b_if_req, b_if_valid, b_if_stall, b_d_req, b_d_we, b_d_valid, b_d_stall;
   logic        b_mem_en, b_mem_we, b_busy;
   logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_wdata;
   logic [31:0] b_mem_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
      .d_valid(d_valid), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(2)) dut_b (
      .clk(clk), .rst(rst),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
      .if_stall(b_if_stall),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_rdata(b_d_rdata),
      .d_valid(b_d_valid), .d_stall(b_d_stall),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, ifr;
      logic [31:0] ia;
      logic        dr, dwe;
      logic [31:0] da, dwd, mrd;
      logic        iv;
      logic [31:0] ird;
      logic        is, dv;
      logic [31:0] drd;
      logic        ds, men, mwe;
      logic [31:0] ma, mwd;
      logic        bsy;
   } vec_t;

   vec_t tbl [24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] DB = 32'hDEADBEEF;
   localparam logic [31:0] CF = 32'hCAFEF00D;
   localparam logic [31:0] IW = 32'h12345678;

   initial begin
      //            rst   ifr   ia       dr    dwe   da      dwd       mrd       | iv  ird    is    dv    drd    ds    men   mwe   ma       mwd       busy
      tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,    32'h0,      1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
      tbl[1]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,    32'h0,      1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
      tbl[2]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,    32'h0,      1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,    1'b1};
      tbl[3]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,    32'h0,      1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1};
      tbl[4]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,    DB,         1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1};
      tbl[5]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,    32'h0,      1'b1, DB,    1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1};
      tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,    32'h0,      1'b0, DB,    1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
      tbl[7]  = '{1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h40, 32'h0,    32'h0,      1'b0, DB,    1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
      tbl[8]  = '{1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h40, 32'h0,    32'h0,      1'b0, DB,    1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h40,  32'h0,    1'b1};
      tbl[9]  = '{1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h40, 32'h0,    32'h0,      1'b0, DB,    1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1};
      tbl[10] = '{1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h40, 32'h0,    CF,         1'b0, DB,    1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1};
      tbl[11] = '{1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h40, 32'h0,    32'h0,      1'b0, DB,    1'b1, 1'b1, CF,    1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1};
      tbl[12] = '{1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,  32'h0,    32'h0,      1'b0, DB,    1'b1, 1'b0, CF,    1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
      tbl[13] = '{1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,  32'h0,    32'h0,      1'b0, DB,    1'b1, 1'b0, CF,    1'b0, 1'b1, 1'b0, 32'h200, 32'h0,    1'b1};
      tbl[14] = '{1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,  32'h0,    32'h0,      1'b0, DB,    1'b1, 1'b0, CF,    1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1};
      tbl[15] = '{1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,  32'h0,    IW,         1'b0, DB,    1'b1, 1'b0, CF,    1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1};
      tbl[16] = '{1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,  32'h0,    32'h0,      1'b1, IW,    1'b0, 1'b0, CF,    1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1};
      tbl[17] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,    32'h0,      1'b0, IW,    1'b0, 1'b0, CF,    1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
      tbl[18] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h40, 32'h1234, 32'h0,      1'b0, IW,    1'b0, 1'b0, CF,    1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
      tbl[19] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h40, 32'h1234, 32'h0,      1'b0, IW,    1'b0, 1'b0, CF,    1'b1, 1'b1, 1'b1, 32'h40,  32'h1234, 1'b1};
      tbl[20] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h40, 32'h1234, 32'h0,      1'b0, IW,    1'b0, 1'b0, CF,    1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1};
      tbl[21] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h40, 32'h1234, 32'hFFFFFFFF, 1'b0, IW,  1'b0, 1'b0, CF,    1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1};
      tbl[22] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h40, 32'h1234, 32'h0,      1'b0, IW,    1'b0, 1'b1, CF,    1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1};
      tbl[23] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,    32'h0,      1'b0, IW,    1'b0, 1'b0, CF,    1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};

      rst = 1'b1;
      {if_req, d_req, d_we} = 3'b000;
      {if_addr, d_addr, d_wdata, mem_rdata} = {4{32'h0}};
      {b_if_req, b_d_req, b_d_we} = 3'b000;
      {b_if_addr, b_d_addr, b_d_wdata, b_mem_rdata} = {4{32'h0}};
      next_cycle();

      // Single fetch, contended read then fetch, and a write
      for (int i = 0; i < 24; i++) begin
         rst = tbl[i].rst;  if_req = tbl[i].ifr; if_addr = tbl[i].ia;
         d_req = tbl[i].dr; d_we = tbl[i].dwe;   d_addr = tbl[i].da;
         d_wdata = tbl[i].dwd; mem_rdata = tbl[i].mrd;
         @(negedge clk);
         chk($sformatf("row%0d.if_valid", i),  {31'h0, if_valid},  {31'h0, tbl[i].iv});
         chk($sformatf("row%0d.if_rdata", i),  if_rdata,            tbl[i].ird);
         chk($sformatf("row%0d.if_stall", i),  {31'h0, if_stall},  {31'h0, tbl[i].is});
         chk($sformatf("row%0d.d_valid", i),   {31'h0, d_valid},   {31'h0, tbl[i].dv});
         chk($sformatf("row%0d.d_rdata", i),   d_rdata,             tbl[i].drd);
         chk($sformatf("row%0d.d_stall", i),   {31'h0, d_stall},   {31'h0, tbl[i].ds});
         chk($sformatf("row%0d.mem_en", i),    {31'h0, mem_en},    {31'h0, tbl[i].men});
         chk($sformatf("row%0d.mem_we", i),    {31'h0, mem_we},    {31'h0, tbl[i].mwe});
         chk($sformatf("row%0d.mem_addr", i),  mem_addr,            tbl[i].ma);
         chk($sformatf("row%0d.mem_wdata", i), mem_wdata,           tbl[i].mwd);
         chk($sformatf("row%0d.busy", i),      {31'h0, busy},      {31'h0, tbl[i].bsy});
         next_cycle();
      end

      // Reset during WAIT discards the fetch, which is re-issued after release
      if_req = 1'b1; if_addr = 32'h300;
      @(negedge clk);
      chk("rstwait.c0.busy", {31'h0, busy}, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("rstwait.c1.mem_en", {31'h0, mem_en}, 32'h1);
      chk("rstwait.c1.mem_addr", mem_addr, 32'h300);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("rstwait.c2.mem_en", {31'h0, mem_en}, 32'h0);
      chk("rstwait.c2.busy", {31'h0, busy}, 32'h0);
      chk("rstwait.c2.if_valid", {31'h0, if_valid}, 32'h0);
      chk("rstwait.c2.if_stall", {31'h0, if_stall}, 32'h1);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rstwait.c3.if_valid", {31'h0, if_valid}, 32'h0);
      chk("rstwait.c3.mem_en", {31'h0, mem_en}, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("rstwait.c4.mem_en", {31'h0, mem_en}, 32'h1);
      chk("rstwait.c4.mem_addr", mem_addr, 32'h300);
      chk("rstwait.c4.if_valid", {31'h0, if_valid}, 32'h0);
      next_cycle();
      next_cycle();
      mem_rdata = 32'hABCD0001;
      @(negedge clk);
      chk("rstwait.c6.if_valid", {31'h0, if_valid}, 32'h0);
      next_cycle();
      mem_rdata = 32'h0;
      @(negedge clk);
      chk("rstwait.c7.if_valid", {31'h0, if_valid}, 32'h1);
      chk("rstwait.c7.if_rdata", if_rdata, 32'hABCD0001);
      next_cycle();
      if_req = 1'b0;

      // Fetch starvation: D wins twice, then IF is forced, then D again
      for (int c = 0; c < 15; c++) begin
         logic        exp_en;
         logic [31:0] exp_addr;
         b_if_req = 1'b1; b_if_addr = 32'h500; b_d_req = 1'b1;
         b_d_addr = (c < 4) ? 32'h10 : ((c < 8) ? 32'h14 : 32'h18);
         exp_en   = (c == 1) || (c == 5) || (c == 9) || (c == 13);
         exp_addr = (c == 1) ? 32'h10 : (c == 5) ? 32'h14 : (c == 9) ? 32'h500 :
                    (c == 13) ? 32'h18 : 32'h0;
         @(negedge clk);
         chk($sformatf("starve.c%0d.mem_en", c), {31'h0, b_mem_en}, {31'h0, exp_en});
         chk($sformatf("starve.c%0d.mem_addr", c), b_mem_addr, exp_addr);
         next_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port (IF) and the data-access port (MEM stage, D).
- Sequences each access through a fixed-latency memory: issue, wait, response.
- Generates per-port stall signals that the datapath ORs into the PC/IF-ID enable path and the pipeline freeze logic.
- Data port has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to the mem_rdata-valid cycle. Legal range 1..15.
- STARVE_MAX, 4, max consecutive D grants while if_req is pending before IF is forced. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  fetch request; held with if_addr stable until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid when if_valid=1.
- if_valid  out  1  one-cycle completion pulse for IF.
- if_stall  out  1  if_req & ~if_valid.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_valid.
- d_we  in  1  1=write, 0=read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data; valid when d_valid=1 on a read.
- d_valid  out  1  one-cycle completion pulse for D (reads and writes).
- d_stall  out  1  d_req & ~d_valid.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid exactly MEM_LAT cycles after the mem_en cycle.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states:
  - IDLE: grant decision.
  - ACCESS: mem_en=1; mem_addr/mem_we/mem_wdata driven from the latched request.
  - WAIT: MEM_LAT cycles, down-counter of width 4.
  - RESP: winner's valid=1.
- Transitions:
  - IDLE -> ACCESS when (if_req | d_req).
  - ACCESS -> WAIT, counter loaded with MEM_LAT.
  - WAIT -> RESP on the edge ending the last WAIT cycle. mem_rdata is captured into the owner's rdata register on that edge (reads only).
  - RESP -> IDLE unconditionally. No grant is made in RESP, so a requester sees valid in cycle N and presents a fresh req in N+1.
- Latency: req first seen in IDLE at cycle 0 -> mem_en at cycle 1 -> data at cycle 1+MEM_LAT -> valid at cycle 2+MEM_LAT. Next grant decision no earlier than 3+MEM_LAT. Throughput is one access per MEM_LAT+3 cycles.
- Arbitration in IDLE:
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both: grant D unless starve_cnt == STARVE_MAX, then grant IF.
- starve_cnt:
  - +1 on each D grant made while if_req=1.
  - Cleared on an IF grant, or in any IDLE cycle with if_req=0.
  - Saturates at STARVE_MAX.
- Request latching: owner, we, addr and wdata are latched at the grant. Inputs are ignored thereafter until RESP completes.
- Writes: mem_we=1 in ACCESS; still wait MEM_LAT cycles; d_valid pulses in RESP; d_rdata is unchanged.
- mem_we, mem_addr and mem_wdata are zero outside ACCESS.
- Registered outputs at reset: if_rdata=0, d_rdata=0, if_valid=0, d_valid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- Internal state at reset: state=IDLE, starve_cnt=0.
- Stall outputs are combinational: if_stall = if_req & ~if_valid, d_stall = d_req & ~d_valid. Both are 0 during reset whenever the reqs are 0.
- Reset mid-transaction: immediate return to IDLE. The in-flight response is discarded and no valid pulse is produced. Requests still asserted after release are arbitrated afresh.
- A req dropped during ACCESS/WAIT (protocol violation) does not abort the access; valid still pulses.

Test Plan:
1. MEM_LAT=2; if_req=1, if_addr=0x100 at cycle 0; memory returns 0xDEADBEEF at cycle 3 -> mem_en=1 with mem_addr=0x100 at cycle 1 only; if_valid=1 and if_rdata=0xDEADBEEF at cycle 4; if_stall=1 in cycles 0-3 and 0 in cycle 4.
2. if_req and d_req (read 0x40) both asserted at cycle 0; d_req dropped after d_valid -> D access mem_en at cycle 1, d_valid at cycle 4; IF granted at cycle 5, mem_en at cycle 6, if_valid at cycle 9; if_stall=1 in cycles 0-8.
3. Write: d_we=1, d_addr=0x40, d_wdata=0x1234 -> cycle 1 has mem_en=1, mem_we=1, mem_addr=0x40, mem_wdata=0x1234; d_valid at cycle 4; d_rdata keeps its prior value.
4. MEM_LAT=1, STARVE_MAX=2; if_req held high; d_req re-presented every transaction with addresses 0x10, 0x14, 0x18 -> mem_en at cycles 1, 5, 9 with mem_addr 0x10, 0x14, then if_addr; 0x18 served at cycle 13.
5. Reset in WAIT: if_req at cycle 0, rst high in cycle 2 for one cycle -> mem_en=0, no if_valid, busy=0; if_req still high after release -> re-issued with mem_en one cycle after the first IDLE cycle.
